wb_sram_responder: RTL and testbench

- Wishbone classic-cycle responder (slave end) serving an on-chip synchronous SRAM window.
- Answers the cycles issued by the ARM-side Wishbone initiator on the shared adr/dat/we/stb/cyc/tagn bus.
- Adds programmable wait states, echoes the transfer tag, and flags out-of-window accesses with an error termination instead of ack.

---
 rtl/wb_pkg.sv | 16 +
 rtl/wb_sram_array.sv | 36 +++
 rtl/wb_sram_responder.sv | 181 ++++++++++++++++++
 tb/tb_wb_sram_responder.sv | 255 +++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
// Shared Wishbone SRAM responder definitions: bus widths, wait-counter
// width and the responder FSM state encoding.
package wb_pkg;

  localparam int WB_ADDR_W  = 26;
  localparam int WB_DATA_W  = 32;
  localparam int WB_SEL_W   = 4;
  localparam int WAIT_CNT_W = 4;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_WAIT = 2'd1,
    ST_TERM = 2'd2
  } wb_state_e;

endpackage

// File: rtl/wb_sram_array.sv
// Single-port synchronous RAM with byte enables and a registered read port.
// A write and a read of the same word in one cycle returns the new data.
module wb_sram_array #(
  parameter int AW = 10,
  parameter int DW = 32
) (
  input  logic            clk,
  input  logic            we,
  input  logic [DW/8-1:0] be,
  input  logic [AW-1:0]   addr,
  input  logic [DW-1:0]   wdata,
  output logic [DW-1:0]   rdata
);

  logic [DW-1:0] mem_q [2**AW];
  logic [DW-1:0] rdata_q;
  logic [DW-1:0] word_d;

  // Merge enabled write bytes over the stored word; this is both the new
  // stored value and the read result.
  always_comb begin
    word_d = mem_q[addr];
    for (int b = 0; b < DW/8; b++) begin
      if (we && be[b]) word_d[8*b +: 8] = wdata[8*b +: 8];
    end
  end

  // Storage update and registered read.
  always_ff @(posedge clk) begin
    if (we) mem_q[addr] <= word_d;
    rdata_q <= word_d;
  end

  assign rdata = rdata_q;

endmodule

// File: rtl/wb_sram_responder.sv
// Wishbone classic-cycle responder for an on-chip SRAM window with
// programmable wait states, tag echo and error termination outside the
// window. Define WB_SRAM_BYTE_SEL_EN to add sel_i byte enables.
//
// Handshake: a request is accepted when cyc_i & stb_i are high at a rising
// edge in IDLE; exactly one of ack_o/err_o pulses for one cycle to end it,
// unless cyc_i or stb_i drops while waiting, which abandons the transfer.
module wb_sram_responder
  import wb_pkg::*;
#(
  parameter int                ADDR_W      = 26,
  parameter int                DATA_W      = 32,
  parameter int                DEPTH_LOG2  = 10,
  parameter logic [ADDR_W-1:0] BASE_ADDR   = '0,
  parameter int                WAIT_STATES = 1
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic [ADDR_W-1:0] adr_i,
  input  logic [DATA_W-1:0] dat_i,
  input  logic              we_i,
  input  logic              stb_i,
  input  logic              cyc_i,
  input  logic              tagn_i,
`ifdef WB_SRAM_BYTE_SEL_EN
  input  logic [3:0]        sel_i,
`endif
  output logic [DATA_W-1:0] dat_o,
  output logic              ack_o,
  output logic              err_o,
  output logic              tagn_o,
  output wb_state_e         dbg_state_o
);

  localparam int LO = DEPTH_LOG2 + 2;

  wb_state_e             state_q, state_d;
  logic [WAIT_CNT_W-1:0] cnt_q, cnt_d;
  logic [DEPTH_LOG2-1:0] idx_q, idx_d;
  logic [DATA_W-1:0]     wdat_q, wdat_d;
  logic                  we_q, we_d;
  logic                  tag_q, tag_d;
  logic                  win_q, win_d;
  logic [3:0]            sel_q, sel_d;
  logic [DATA_W-1:0]     dat_out_q, dat_out_d;
  logic                  ack_q, ack_d;
  logic                  err_q, err_d;
  logic                  tag_out_q, tag_out_d;

  logic                  in_win;
  logic [3:0]            sel_live;
  logic                  ram_we;
  logic [3:0]            ram_be;
  logic [DEPTH_LOG2-1:0] ram_addr;
  logic [DATA_W-1:0]     ram_wdata;
  logic [DATA_W-1:0]     ram_rdata;
  logic                  unused_adr;

  assign in_win     = (adr_i[ADDR_W-1:LO] == BASE_ADDR[ADDR_W-1:LO]);
  assign unused_adr = ^adr_i[1:0];

`ifdef WB_SRAM_BYTE_SEL_EN
  assign sel_live = sel_i;
`else
  assign sel_live = 4'hF;
`endif

  // Next-state, capture, RAM access and registered-output decisions.
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    idx_d     = idx_q;
    wdat_d    = wdat_q;
    we_d      = we_q;
    tag_d     = tag_q;
    win_d     = win_q;
    sel_d     = sel_q;
    ack_d     = 1'b0;
    err_d     = 1'b0;
    tag_out_d = 1'b0;
    dat_out_d = '0;
    ram_we    = 1'b0;
    ram_addr  = idx_q;
    ram_wdata = wdat_q;
    ram_be    = sel_q;
    case (state_q)
      ST_IDLE: begin
        if (cyc_i && stb_i) begin
          idx_d     = adr_i[LO-1:2];
          wdat_d    = dat_i;
          we_d      = we_i;
          tag_d     = tagn_i;
          win_d     = in_win;
          sel_d     = sel_live;
          // Live inputs feed the RAM so a zero-wait write lands this edge.
          ram_addr  = adr_i[LO-1:2];
          ram_wdata = dat_i;
          ram_be    = sel_live;
          if (WAIT_STATES == 0) begin
            state_d = ST_TERM;
            ram_we  = we_i && in_win;
          end else begin
            state_d = ST_WAIT;
            cnt_d   = WAIT_CNT_W'(WAIT_STATES);
          end
        end
      end
      ST_WAIT: begin
        if (!(cyc_i && stb_i)) begin
          state_d = ST_IDLE;
          cnt_d   = '0;
        end else if (cnt_q <= WAIT_CNT_W'(1)) begin
          state_d = ST_TERM;
          cnt_d   = '0;
          ram_we  = we_q && win_q;
        end else begin
          cnt_d = cnt_q - WAIT_CNT_W'(1);
        end
      end
      ST_TERM: begin
        state_d   = ST_IDLE;
        ack_d     = win_q;
        err_d     = !win_q;
        tag_out_d = tag_q;
        dat_out_d = (win_q && !we_q) ? ram_rdata : '0;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // State, holding and output registers with synchronous reset.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q   <= ST_IDLE;
      cnt_q     <= '0;
      idx_q     <= '0;
      wdat_q    <= '0;
      we_q      <= 1'b0;
      tag_q     <= 1'b0;
      win_q     <= 1'b0;
      sel_q     <= '0;
      dat_out_q <= '0;
      ack_q     <= 1'b0;
      err_q     <= 1'b0;
      tag_out_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      idx_q     <= idx_d;
      wdat_q    <= wdat_d;
      we_q      <= we_d;
      tag_q     <= tag_d;
      win_q     <= win_d;
      sel_q     <= sel_d;
      dat_out_q <= dat_out_d;
      ack_q     <= ack_d;
      err_q     <= err_d;
      tag_out_q <= tag_out_d;
    end
  end

  // Reset suppresses any write that would otherwise land this edge.
  wb_sram_array #(
    .AW (DEPTH_LOG2),
    .DW (DATA_W)
  ) u_array (
    .clk   (clk_i),
    .we    (ram_we && !rst_i),
    .be    (ram_be),
    .addr  (ram_addr),
    .wdata (ram_wdata),
    .rdata (ram_rdata)
  );

  assign dat_o       = dat_out_q;
  assign ack_o       = ack_q;
  assign err_o       = err_q;
  assign tagn_o      = tag_out_q;
  assign dbg_state_o = state_q;

endmodule

// File: tb/tb_wb_sram_responder.sv
// Randomized scoreboard bench for wb_sram_responder (WAIT_STATES = 1,
// DEPTH_LOG2 = 10, BASE_ADDR = 0). Byte-enable checks are built when
// WB_SRAM_BYTE_SEL_EN is defined.
module tb_wb_sram_responder;
  import wb_pkg::*;

  localparam int WS = 1;

  // ---------------- clock / reset ----------------
  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic [25:0] adr_i = '0;
  logic [31:0] dat_i = '0;
  logic        we_i = 1'b0;
  logic        stb_i = 1'b0;
  logic        cyc_i = 1'b0;
  logic        tagn_i = 1'b0;
  logic [3:0]  sel_i = 4'hF;
  logic [31:0] dat_o;
  logic        ack_o;
  logic        err_o;
  logic        tagn_o;
  wb_state_e   dbg_state_o;

  always #5 clk_i = ~clk_i;

  wb_sram_responder #(
    .ADDR_W      (26),
    .DATA_W      (32),
    .DEPTH_LOG2  (10),
    .BASE_ADDR   (26'h0),
    .WAIT_STATES (WS)
  ) dut (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .adr_i       (adr_i),
    .dat_i       (dat_i),
    .we_i        (we_i),
    .stb_i       (stb_i),
    .cyc_i       (cyc_i),
    .tagn_i      (tagn_i),
`ifdef WB_SRAM_BYTE_SEL_EN
    .sel_i       (sel_i),
`endif
    .dat_o       (dat_o),
    .ack_o       (ack_o),
    .err_o       (err_o),
    .tagn_o      (tagn_o),
    .dbg_state_o (dbg_state_o)
  );

  // ---------------- scoreboard state ----------------
  // Entry layout: {is_err, tag, is_read, data}
  logic [34:0] exp_q[$];
  logic [31:0] model_mem [1024];
  int n_checks = 0;
  int n_fail   = 0;
  logic prev_term = 1'b0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive(input logic [25:0] adr, input logic [31:0] dat,
                       input logic we, input logic tag, input logic [3:0] sel);
    adr_i = adr; dat_i = dat; we_i = we; tagn_i = tag; sel_i = sel;
    cyc_i = 1'b1; stb_i = 1'b1;
  endtask

  // Drive a request and record the response the reference model predicts.
  task automatic issue(input logic [25:0] adr, input logic [31:0] dat,
                       input logic we, input logic tag, input logic [3:0] sel);
    int idx;
    logic [3:0] be;
    drive(adr, dat, we, tag, sel);
    idx = int'(adr[11:2]);
`ifdef WB_SRAM_BYTE_SEL_EN
    be = sel;
`else
    be = 4'hF;
`endif
    if (adr[25:12] != 14'd0) begin
      exp_q.push_back({1'b1, tag, !we, 32'h0});
    end else if (we) begin
      for (int b = 0; b < 4; b++)
        if (be[b]) model_mem[idx][8*b +: 8] = dat[8*b +: 8];
      exp_q.push_back({1'b0, tag, 1'b0, 32'h0});
    end else begin
      exp_q.push_back({1'b0, tag, 1'b1, model_mem[idx]});
    end
  endtask

  task automatic go_idle();
    cyc_i = 1'b0; stb_i = 1'b0; we_i = 1'b0;
  endtask

  // Bounded wait for a termination; latency counted in falling edges.
  task automatic wait_term();
    int lat = 0;
    bit got = 0;
    while (!got && lat < 20) begin
      @(negedge clk_i);
      lat++;
      if (ack_o || err_o) got = 1;
    end
    if (!got) begin
      chk("term_timeout", 32'd0, 32'd1);
      if (exp_q.size() > 0) void'(exp_q.pop_front());
    end else begin
      chk("latency", 32'(lat), 32'(WS + 2));
    end
  endtask

  task automatic xfer(input logic [25:0] adr, input logic [31:0] dat,
                      input logic we, input logic tag, input logic [3:0] sel);
    @(negedge clk_i);
    issue(adr, dat, we, tag, sel);
    wait_term();
    go_idle();
  endtask

  // Count terminations over a window where none are expected.
  task automatic expect_quiet(input string name, input int cycles);
    int terms = 0;
    repeat (cycles) begin
      @(negedge clk_i);
      if (ack_o || err_o) terms++;
    end
    chk(name, 32'(terms), 32'd0);
  endtask

  // ---------------- monitor ----------------
  always @(negedge clk_i) begin
    logic [34:0] e;
    if (!rst_i) begin
      if (ack_o || err_o) begin
        chk("ack_err_exclusive", {31'd0, ack_o && err_o}, 32'd0);
        chk("no_consecutive_term", {31'd0, prev_term}, 32'd0);
        if (exp_q.size() == 0) begin
          chk("unexpected_term", 32'd1, 32'd0);
        end else begin
          e = exp_q.pop_front();
          chk("term_kind_err", {31'd0, err_o}, {31'd0, e[34]});
          chk("tag_echo", {31'd0, tagn_o}, {31'd0, e[33]});
          if (e[34] || e[32]) chk("read_data", dat_o, e[31:0]);
        end
      end else if (dat_o !== 32'h0 || tagn_o !== 1'b0) begin
        chk("idle_outputs_zero", {dat_o[30:0], tagn_o}, 32'h0);
      end
      prev_term <= ack_o || err_o;
    end else begin
      prev_term <= 1'b0;
    end
  end

  // ---------------- stimulus ----------------
  initial begin
    logic [25:0] a;
    int idx;
    logic [3:0] s;

    // Reset state.
    repeat (3) @(posedge clk_i);
    @(negedge clk_i);
    chk("rst_ack", {31'd0, ack_o}, 32'd0);
    chk("rst_err", {31'd0, err_o}, 32'd0);
    chk("rst_dat", dat_o, 32'd0);
    chk("rst_tag", {31'd0, tagn_o}, 32'd0);
    chk("rst_state", {30'd0, dbg_state_o}, {30'd0, ST_IDLE});
    rst_i = 1'b0;

    // Initialise words 0..63 so every later read has a known value.
    for (int i = 0; i < 64; i++)
      xfer(26'(i * 4), $urandom, 1'b1, 1'($urandom_range(0, 1)), 4'hF);

    // Directed write/read of DEADBEEF with tag 1.
    xfer(26'h0000010, 32'hDEADBEEF, 1'b1, 1'b1, 4'hF);
    xfer(26'h0000010, 32'h0, 1'b0, 1'b0, 4'hF);
    chk("model_deadbeef", model_mem[4], 32'hDEADBEEF);

    // Out of window read and write; aliased word 0 must be untouched.
    xfer(26'h0001000, 32'h0, 1'b0, 1'b1, 4'hF);
    xfer(26'h0001000, 32'hCAFEF00D, 1'b1, 1'b0, 4'hF);
    xfer(26'h0000000, 32'h0, 1'b0, 1'b0, 4'hF);

    // Abort: drop cyc during WAIT on a write.
    @(negedge clk_i);
    drive(26'h0000010, 32'h12345678, 1'b1, 1'b0, 4'hF);
    @(negedge clk_i);
    cyc_i = 1'b0; stb_i = 1'b0;
    expect_quiet("abort_no_term", 5);
    xfer(26'h0000010, 32'h0, 1'b0, 1'b1, 4'hF);

    // Reset for 2 cycles while a write sits in WAIT.
    @(negedge clk_i);
    drive(26'h0000014, 32'h0BADF00D, 1'b1, 1'b1, 4'hF);
    @(negedge clk_i);
    chk("pre_rst_state", {30'd0, dbg_state_o}, {30'd0, ST_WAIT});
    rst_i = 1'b1;
    go_idle();
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    chk("midrst_ack", {31'd0, ack_o}, 32'd0);
    chk("midrst_err", {31'd0, err_o}, 32'd0);
    chk("midrst_dat", dat_o, 32'd0);
    chk("midrst_tag", {31'd0, tagn_o}, 32'd0);
    rst_i = 1'b0;
    xfer(26'h0000014, 32'h0, 1'b0, 1'b0, 4'hF);

    // Back-to-back: 4 writes then 4 reads with stb held high.
    @(negedge clk_i);
    issue(26'h0000020, $urandom, 1'b1, 1'b1, 4'hF);
    for (int i = 1; i < 8; i++) begin
      wait_term();
      if (i < 4) issue(26'(32 + 4 * i), $urandom, 1'b1, 1'($urandom_range(0, 1)), 4'hF);
      else       issue(26'(32 + 4 * (i - 4)), 32'h0, 1'b0, 1'($urandom_range(0, 1)), 4'hF);
    end
    wait_term();
    go_idle();

`ifdef WB_SRAM_BYTE_SEL_EN
    xfer(26'h0000050, 32'hFFFFFFFF, 1'b1, 1'b0, 4'hF);
    xfer(26'h0000050, 32'h00000000, 1'b1, 1'b0, 4'b0101);
    xfer(26'h0000050, 32'h0, 1'b0, 1'b1, 4'b0000);
    chk("model_bytesel", model_mem[20], 32'hFF00FF00);
    xfer(26'h0000050, 32'h12345678, 1'b1, 1'b1, 4'b0000);
    xfer(26'h0000050, 32'h0, 1'b0, 1'b0, 4'hF);
`endif

    // Randomized mix of in-window and out-of-window transfers.
    for (int i = 0; i < 200; i++) begin
      if ($urandom_range(0, 7) == 0) begin
        a = {14'($urandom_range(1, 16383)), 12'($urandom_range(0, 4095))};
      end else begin
        idx = $urandom_range(0, 63);
        a = 26'(idx * 4 + $urandom_range(0, 3));
      end
      s = 4'($urandom_range(0, 15));
      xfer(a, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)), s);
      repeat ($urandom_range(0, 2)) @(negedge clk_i);
    end

    repeat (4) @(negedge clk_i);
    chk("queue_drained", 32'(exp_q.size()), 32'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
